// File: rtl/moving_avg_pkg.sv
// Shared types and default sizes for the moving-average filter sequencer.
//   state_t          : sequencer states (idle / update / present output)
//   DATA_W_DEF       : default sample width
//   DEPTH_LOG2_DEF   : default log2 of the tap count
package moving_avg_pkg;

  localparam int DATA_W_DEF     = 24;
  localparam int DEPTH_LOG2_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_OUT
  } state_t;

endpackage

// File: rtl/moving_avg_ctrl_sample_ring.sv
// Circular history buffer holding the last N scaled samples.
// Ports:
//   Clock   : rising-edge clock
//   reset_n : asynchronous active-low clear of every entry
//   we      : write enable
//   addr    : shared read/write address
//   wdata   : write data
//   rdata   : asynchronous read of entry addr
module sample_ring #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                     Clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [DEPTH_LOG2-1:0]    addr,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rdata
);

  localparam int N = 1 << DEPTH_LOG2;

  logic signed [DATA_W-1:0] r_mem [N];

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/moving_avg_ctrl.sv
// N-tap moving-average sequencer. Each accepted sample is scaled by 1/N
// (truncating toward zero), written into a circular history, and folded into
// a running sum (add newest, subtract the sample it overwrites once the
// history is full). The sum is presented with a valid/ready handshake.
// Ports:
//   Clock, reset_n       : clock and asynchronous active-low reset
//   clear                : synchronous flush of sum/count/pointer and state
//   in_valid/in_data     : upstream sample, accepted when in_ready is high
//   in_ready             : sequencer idle and able to take a sample
//   out_valid/out_data   : filtered sample (running sum)
//   out_ready            : downstream accepts out_data
//   count                : number of filled taps, saturates at N
//   primed               : count == N
module moving_avg_ctrl
  import moving_avg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                     Clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic [DEPTH_LOG2:0]      count,
  output logic                     primed
);

  localparam int                  N     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] N_CNT = (DEPTH_LOG2 + 1)'(N);

  // Signed divide by N rounding toward zero: negative values get N-1 added
  // before the arithmetic shift so that e.g. -1/8 gives 0, not -1.
  function automatic logic signed [DATA_W-1:0] div_n(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] bias;
    bias = x[DATA_W-1] ? DATA_W'(N - 1) : '0;
    return (x + bias) >>> DEPTH_LOG2;
  endfunction

  state_t                   r_state;
  state_t                   w_next;
  logic signed [DATA_W-1:0] r_scaled;
  logic signed [DATA_W-1:0] r_sum;
  logic [DEPTH_LOG2-1:0]    r_wr_ptr;
  logic [DEPTH_LOG2:0]      r_count;
  logic signed [DATA_W-1:0] w_oldest;
  logic signed [DATA_W-1:0] w_sub;
  logic                     w_accept;
  logic                     w_update;

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_update  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // clear wins over a simultaneous sample, so do not advertise ready
        in_ready = reset_n && !clear;
        if (in_valid && !clear) begin
          w_accept = 1'b1;
          w_next   = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_update = !clear;
        w_next   = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  // Stale ring entries after clear are never subtracted: only a full
  // history contributes its oldest entry.
  assign w_sub = (r_count == N_CNT) ? w_oldest : '0;

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scaled <= '0;
      r_sum    <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_sum    <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_scaled <= div_n(in_data);
      if (w_update) begin
        r_sum    <= r_sum + r_scaled - w_sub;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != N_CNT) r_count <= r_count + 1'b1;
      end
    end
  end

  sample_ring #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ring (
    .Clock  (Clock),
    .reset_n(reset_n),
    .we     (w_update),
    .addr   (r_wr_ptr),
    .wdata  (r_scaled),
    .rdata  (w_oldest)
  );

  assign out_data = r_sum;
  assign count    = r_count;
  assign primed   = (r_count == N_CNT);

endmodule

// File: tb/tb_moving_avg_ctrl.sv
module tb_moving_avg_ctrl;

  localparam int DATA_W     = 24;
  localparam int DEPTH_LOG2 = 3;

  logic                     Clock = 1'b0;
  logic                     reset_n;
  logic                     clear;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_ready;
  logic [DEPTH_LOG2:0]      count;
  logic                     primed;

  moving_avg_ctrl #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .Clock    (Clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .primed   (primed)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int data;
    int cnt;
    int prm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: a result is consumed on the cycle it is handshaken.
  always @(negedge Clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", int'(out_data), 32'h7fffffff);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("count", int'(count), e.cnt);
        chk("primed", int'(primed), e.prm);
      end
    end
  end

  task automatic push(input int d, input int c, input int p);
    exp_t e;
    e.data = d; e.cnt = c; e.prm = p;
    q.push_back(e);
  endtask

  // Offer one sample and return #1 after the edge that accepted it.
  task automatic send(input int d, input bit do_push, input int ed, input int ec, input int ep);
    int n = 0;
    @(negedge Clock);
    while (!in_ready && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_data  = d;
    in_valid = 1'b1;
    if (do_push) push(ed, ec, ep);
    @(posedge Clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge Clock);
      #1 n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_primed"}, int'(primed), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int held;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    do_reset();

    // 8 x 128 -> 16..128, primed on the 8th
    for (int k = 1; k <= 8; k++) send(128, 1, 16 * k, k, (k == 8) ? 1 : 0);
    // 8 x 0 -> 112..0
    for (int k = 1; k <= 8; k++) send(0, 1, 128 - 16 * k, 8, 1);
    drain();

    // -1/8 truncates to 0, -9/8 to -1
    do_reset();
    for (int k = 1; k <= 8; k++) send(-1, 1, 0, k, (k == 8) ? 1 : 0);
    for (int k = 1; k <= 8; k++) send(-9, 1, -k, 8, 1);
    drain();

    // Backpressure: sum -8 with ring all -1; 8 -> -6, then 16 -> -3
    @(posedge Clock);
    #1 out_ready = 1'b0;
    send(8, 1, -6, 8, 1);
    in_data  = 16;
    in_valid = 1'b1;
    push(-3, 8, 1);
    n = 0;
    @(negedge Clock);
    while (!out_valid && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("stall_out_valid_seen", int'(out_valid), 1);
    held = int'(out_data);
    chk("stall_initial_data", held, -6);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_out_data", int'(out_data), held);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge Clock);
    #1 out_ready = 1'b1;
    n = 0;
    @(negedge Clock);
    while (!in_ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("held_sample_ready", int'(in_ready), 1);
    @(posedge Clock);
    #1 in_valid = 1'b0;
    drain();

    // Clear while a result is pending in S_OUT
    do_reset();
    for (int k = 1; k <= 8; k++) send(800, 1, 100 * k, k, (k == 8) ? 1 : 0);
    drain();
    @(posedge Clock);
    #1 out_ready = 1'b0;
    send(800, 0, 0, 0, 0);
    n = 0;
    @(negedge Clock);
    while (!out_valid && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("pre_clear_out_valid", int'(out_valid), 1);
    @(posedge Clock);
    #1 clear = 1'b1;
    @(posedge Clock);
    #1 clear = 1'b0;
    @(negedge Clock);
    chk("clear_out_valid", int'(out_valid), 0);
    chk("clear_count", int'(count), 0);
    chk("clear_primed", int'(primed), 0);
    chk("clear_in_ready", int'(in_ready), 1);
    @(posedge Clock);
    #1 out_ready = 1'b1;
    send(800, 1, 100, 1, 0);
    drain();

    // Asynchronous reset while in S_UPDATE
    send(64, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge Clock);
    reset_n = 1'b1;
    send(64, 1, 8, 1, 0);
    drain();

    repeat (3) @(posedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
